// File: rtl/issue_pkg.sv
// Shared definitions for the issue arbiter: CDB source encodings,
// default unit latencies and the CDB reservation slot type.
package issue_pkg;

    localparam logic [1:0] SRC_INT = 2'd0;
    localparam logic [1:0] SRC_LSB = 2'd1;
    localparam logic [1:0] SRC_MUL = 2'd2;
    localparam logic [1:0] SRC_DIV = 2'd3;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 7;

    typedef struct packed {
        logic       valid;
        logic [1:0] src;
    } slot_t;

endpackage

// File: rtl/issue_unit_cdb_slot_shifter.sv
// CDB reservation vector S[0..DEPTH]. Every cycle the vector shifts one
// slot toward S[0]; an insert at depth k lands in S'[k] on the same edge.
// S[0] is register-driven and forms the CDB source select.
module cdb_slot_shifter
    import issue_pkg::*;
#(
    parameter int DEPTH = MUL_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DEPTH:0]        ins_vld,
    input  logic [DEPTH:0][1:0]   ins_src,
    output logic [DEPTH:0]        slot_vld,
    output slot_t                 slot0
);

    slot_t s [0:DEPTH];

    // Shift reservations down one slot per cycle, merge inserts, clear on request.
    always_ff @(posedge clk) begin
        for (int k = 0; k <= DEPTH; k++) begin
            if (clr) begin
                s[k] <= '0;
            end else if (ins_vld[k]) begin
                s[k] <= '{valid: 1'b1, src: ins_src[k]};
            end else if (k < DEPTH) begin
                s[k] <= s[k+1];
            end else begin
                s[k] <= '0;
            end
        end
    end

    // Expose the per-slot valid bits for the grant checks.
    always_comb begin
        for (int k = 0; k <= DEPTH; k++) begin
            slot_vld[k] = s[k].valid;
        end
    end

    assign slot0 = s[0];

endmodule

// File: rtl/issue_unit.sv
// Issue arbiter: grants at most one instruction per issue queue per cycle
// such that no two results ever collide on the single CDB.
// Optional feature macro: ISSUE_DIV_EN (divider arbitration and div_cnt).
module issue_unit
    import issue_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       IssueInt_Ready,
    input  logic       IssueLsb_Ready,
    input  logic       IssueMul_Ready,
    input  logic       IssueDiv_Ready,
    input  logic       RB_Flush_Valid,
    output logic       Issue_Int,
    output logic       Issue_Lsb,
    output logic       Issue_Mul,
    output logic       Issue_Div,
    output logic       Cdb_Sel_Valid,
    output logic [1:0] Cdb_Sel
);

`ifdef ISSUE_DIV_EN
    localparam int DEPTH = DIV_LAT;
`else
    localparam int DEPTH = MUL_LAT;
`endif

    logic [DEPTH:0]      slot_vld;
    slot_t               slot0;
    logic [DEPTH:0]      ins_vld;
    logic [DEPTH:0][1:0] ins_src;
    logic                rr;
    logic                block;
    logic                int_elig;
    logic                lsb_elig;
    logic                unused_bits;

    // Reset beats flush, flush beats grants: either one suppresses all issue.
    assign block    = Rst | RB_Flush_Valid;
    assign int_elig = IssueInt_Ready & ~slot_vld[1];
    assign lsb_elig = IssueLsb_Ready & ~slot_vld[1];

    // INT and LSB share the next-cycle slot; rr breaks the tie.
    always_comb begin
        Issue_Int = ~block & int_elig & (~lsb_elig | ~rr);
        Issue_Lsb = ~block & lsb_elig & (~int_elig | rr);
        Issue_Mul = ~block & IssueMul_Ready & ~slot_vld[MUL_LAT];
    end

`ifdef ISSUE_DIV_EN
    localparam int CNT_W = $clog2(DIV_LAT);
    logic [CNT_W-1:0] div_cnt;

    // Non-pipelined divider: needs its CDB slot free and the unit idle.
    always_comb begin
        Issue_Div = ~block & IssueDiv_Ready & ~slot_vld[DIV_LAT] & (div_cnt == '0);
    end

    // Divider busy countdown, reloaded on every divide issue.
    always_ff @(posedge Clk) begin
        if (Rst || RB_Flush_Valid) begin
            div_cnt <= '0;
        end else if (Issue_Div) begin
            div_cnt <= CNT_W'(DIV_LAT - 1);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign unused_bits = &{1'b0, slot_vld[0]};
`else
    assign Issue_Div   = 1'b0;
    assign unused_bits = &{1'b0, IssueDiv_Ready, slot_vld[0], (DIV_LAT > MUL_LAT)};
`endif

    // Each grant reserves the CDB slot L-1 deep, which reaches S[0] at t+L.
    always_comb begin
        ins_vld = '0;
        ins_src = '0;
        if (Issue_Int) begin
            ins_vld[0] = 1'b1;
            ins_src[0] = SRC_INT;
        end else if (Issue_Lsb) begin
            ins_vld[0] = 1'b1;
            ins_src[0] = SRC_LSB;
        end
        if (Issue_Mul) begin
            ins_vld[MUL_LAT-1] = 1'b1;
            ins_src[MUL_LAT-1] = SRC_MUL;
        end
`ifdef ISSUE_DIV_EN
        if (Issue_Div) begin
            ins_vld[DIV_LAT-1] = 1'b1;
            ins_src[DIV_LAT-1] = SRC_DIV;
        end
`endif
    end

    // Round-robin pointer flips only when INT and LSB actually contended.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr <= 1'b0;
        end else if (!RB_Flush_Valid && int_elig && lsb_elig) begin
            rr <= ~rr;
        end
    end

    cdb_slot_shifter #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk      (Clk),
        .clr      (block),
        .ins_vld  (ins_vld),
        .ins_src  (ins_src),
        .slot_vld (slot_vld),
        .slot0    (slot0)
    );

    assign Cdb_Sel_Valid = slot0.valid;
    assign Cdb_Sel       = slot0.src;

endmodule
